// File: rtl/alu_datapath_sequencer.sv
// Command-driven control sequencer for the alu_reg_ram datapath.
// Accepts one command at a time, drives regfile/ALU/RAM controls, captures
// the ALU result and returns it over a response handshake.
module alu_datapath_sequencer #(
  parameter int DATA_W      = 64,
  parameter int REG_AW      = 5,
  parameter int SEL_W       = 5,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_srcA,
  input  logic [REG_AW-1:0] cmd_srcB,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic              cmd_cin,
  input  logic              cmd_muxSel,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [DATA_W-1:0] aluOut,
  input  logic              Cout,
  input  logic [3:0]        status,
  output logic              write,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] data,
  output logic [REG_AW-1:0] readA,
  output logic [REG_AW-1:0] readB,
  output logic [SEL_W-1:0]  sel,
  output logic              muxSel,
  output logic              cin,
  output logic              writeRam,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic [3:0]        rsp_status,
  output logic [15:0]       op_count
);

  // A zero hold time is meaningless; clamp it to one cycle.
  localparam int unsigned EC = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int CW = (EC > 1) ? $clog2(EC) : 1;
  localparam logic [CW-1:0] LAST = CW'(EC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB, RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        kind_q, kind_n;
  logic [REG_AW-1:0] dst_q, dst_n;

  logic              cmd_ready_n, write_n, writeRam_n, rsp_valid_n;
  logic [REG_AW-1:0] writeReg_n, readA_n, readB_n;
  logic [DATA_W-1:0] data_n, rsp_result_n;
  logic [SEL_W-1:0]  sel_n;
  logic              muxSel_n, cin_n, rsp_cout_n;
  logic [3:0]        rsp_status_n;
  logic [15:0]       op_count_n;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state plus next value of every registered output. Outputs are
  // computed for the state being entered, so they line up with that state.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    kind_n       = kind_q;
    dst_n        = dst_q;
    cmd_ready_n  = 1'b0;
    write_n      = 1'b0;
    writeRam_n   = 1'b0;
    rsp_valid_n  = 1'b0;
    writeReg_n   = writeReg;
    data_n       = data;
    readA_n      = readA;
    readB_n      = readB;
    sel_n        = sel;
    muxSel_n     = muxSel;
    cin_n        = cin;
    rsp_result_n = rsp_result;
    rsp_cout_n   = rsp_cout;
    rsp_status_n = rsp_status;
    op_count_n   = op_count;
    unique case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          kind_n      = cmd_kind;
          dst_n       = cmd_dst;
          unique case (cmd_kind)
            2'd0: begin
              state_n    = LOAD;
              write_n    = 1'b1;
              writeReg_n = cmd_dst;
              data_n     = cmd_imm;
            end
            2'd1, 2'd2: begin
              state_n    = EXEC;
              cnt_n      = '0;
              readA_n    = cmd_srcA;
              readB_n    = cmd_srcB;
              sel_n      = cmd_sel;
              cin_n      = cmd_cin;
              muxSel_n   = cmd_muxSel;
              writeRam_n = (cmd_kind == 2'd1) && (EC == 1);
            end
            default: op_count_n = op_count + 16'd1;
          endcase
        end
      end
      LOAD: begin
        op_count_n  = op_count + 16'd1;
        cmd_ready_n = 1'b1;
        state_n     = IDLE;
      end
      EXEC: begin
        if (cnt == LAST) begin
          rsp_result_n = aluOut;
          rsp_cout_n   = Cout;
          rsp_status_n = status;
          if (kind_q == 2'd1) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
          end else begin
            state_n    = WB;
            write_n    = 1'b1;
            writeReg_n = dst_q;
            data_n     = aluOut;
          end
        end else begin
          cnt_n      = cnt + CW'(1);
          writeRam_n = (kind_q == 2'd1) && ((cnt + CW'(1)) == LAST);
        end
      end
      WB: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_n  = op_count + 16'd1;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end else begin
          rsp_valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output and command-field registers; reset aborts any command in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      kind_q     <= '0;
      dst_q      <= '0;
      cmd_ready  <= 1'b0;
      write      <= 1'b0;
      writeRam   <= 1'b0;
      rsp_valid  <= 1'b0;
      writeReg   <= '0;
      data       <= '0;
      readA      <= '0;
      readB      <= '0;
      sel        <= '0;
      muxSel     <= 1'b0;
      cin        <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_status <= '0;
      op_count   <= '0;
    end else begin
      cnt        <= cnt_n;
      kind_q     <= kind_n;
      dst_q      <= dst_n;
      cmd_ready  <= cmd_ready_n;
      write      <= write_n;
      writeRam   <= writeRam_n;
      rsp_valid  <= rsp_valid_n;
      writeReg   <= writeReg_n;
      data       <= data_n;
      readA      <= readA_n;
      readB      <= readB_n;
      sel        <= sel_n;
      muxSel     <= muxSel_n;
      cin        <= cin_n;
      rsp_result <= rsp_result_n;
      rsp_cout   <= rsp_cout_n;
      rsp_status <= rsp_status_n;
      op_count   <= op_count_n;
    end
  end

endmodule

// File: tb/tb_alu_datapath_sequencer.sv
// Self-checking bench for alu_datapath_sequencer: directed table, a held
// response with cmd_valid asserted, reset during EXEC, and random commands.
module tb_alu_datapath_sequencer;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int SW = 5;
  localparam int EC = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_kind = '0;
  logic [AW-1:0] cmd_dst = '0, cmd_srcA = '0, cmd_srcB = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          cmd_cin = 1'b0, cmd_muxSel = 1'b0;
  logic [DW-1:0] cmd_imm = '0;
  logic [DW-1:0] aluOut = '0;
  logic          Cout = 1'b0;
  logic [3:0]    status = '0;
  logic          write, writeRam, muxSel, cin, rsp_valid, rsp_cout;
  logic [AW-1:0] writeReg, readA, readB;
  logic [DW-1:0] data, rsp_result;
  logic [SW-1:0] sel;
  logic          rsp_ready = 1'b0;
  logic [3:0]    rsp_status;
  logic [15:0]   op_count;

  always #5 clock = ~clock;

  alu_datapath_sequencer #(
    .DATA_W(DW), .REG_AW(AW), .SEL_W(SW), .EXEC_CYCLES(EC)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_dst(cmd_dst), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
    .cmd_sel(cmd_sel), .cmd_cin(cmd_cin), .cmd_muxSel(cmd_muxSel),
    .cmd_imm(cmd_imm), .aluOut(aluOut), .Cout(Cout), .status(status),
    .write(write), .writeReg(writeReg), .data(data),
    .readA(readA), .readB(readB), .sel(sel), .muxSel(muxSel), .cin(cin),
    .writeRam(writeRam), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_status(rsp_status),
    .op_count(op_count)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  dst, srca, srcb, sel;
    logic        cin, mux;
    logic [63:0] imm, res;
    logic        cout;
    logic [3:0]  st;
    int          rdelay;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rsp;
  } vec_t;

  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] exp_ops = '0;
  logic        keep_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".cmd_ready"}, cmd_ready, 0);
    chk({tag, ".write"}, write, 0);
    chk({tag, ".writeRam"}, writeRam, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".op_count"}, op_count, 0);
    chk({tag, ".writeReg"}, writeReg, 0);
    chk({tag, ".data"}, data, 0);
    chk({tag, ".readA"}, readA, 0);
    chk({tag, ".readB"}, readB, 0);
    chk({tag, ".sel"}, sel, 0);
    chk({tag, ".cin_mux"}, {cin, muxSel}, 0);
    chk({tag, ".rsp_result"}, rsp_result, 0);
    chk({tag, ".rsp_cs"}, {rsp_cout, rsp_status}, 0);
  endtask

  function automatic vec_t mk(input logic [1:0] k, input logic [4:0] d, a, b, s,
                              input logic ci, mx, input logic [63:0] imm, res,
                              input logic co, input logic [3:0] st, input int rd);
    vec_t v;
    v.kind = k; v.dst = d; v.srca = a; v.srcb = b; v.sel = s;
    v.cin = ci; v.mux = mx; v.imm = imm; v.res = res; v.cout = co; v.st = st;
    v.rdelay = rd;
    v.exp_wdata = (k == 2'd0) ? imm : res;
    v.exp_rsp = res;
    return v;
  endfunction

  // Datapath output is only meaningful on the last hold cycle; elsewhere it is
  // the inverse, so a capture on any other cycle shows up as a wrong result.
  task automatic run_cmd(input vec_t v);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_kind = v.kind; cmd_dst = v.dst; cmd_srcA = v.srca; cmd_srcB = v.srcb;
    cmd_sel = v.sel; cmd_cin = v.cin; cmd_muxSel = v.mux; cmd_imm = v.imm;
    cmd_valid = 1'b1;
    rsp_ready = (v.rdelay == 0);
    aluOut = ~v.res; Cout = ~v.cout; status = ~v.st;
    step();
    cmd_valid = keep_valid;
    if (v.kind == 2'd0) begin
      chk("load.write", write, 1);
      chk("load.writeReg", writeReg, v.dst);
      chk("load.data", data, v.exp_wdata);
      chk("load.writeRam", writeRam, 0);
      chk("load.cmd_ready", cmd_ready, 0);
      step();
      exp_ops++;
      chk("load.write_end", write, 0);
      chk("load.op_count", op_count, exp_ops);
      chk("load.cmd_ready_end", cmd_ready, 1);
    end else if (v.kind == 2'd3) begin
      chk("nop.write", write, 0);
      chk("nop.cmd_ready", cmd_ready, 0);
      exp_ops++;
      chk("nop.op_count", op_count, exp_ops);
      step();
      chk("nop.cmd_ready_end", cmd_ready, 1);
    end else begin
      for (int i = 1; i <= EC; i++) begin
        if (i == EC) begin
          aluOut = v.res; Cout = v.cout; status = v.st;
        end
        chk("exec.readA", readA, v.srca);
        chk("exec.readB", readB, v.srcb);
        chk("exec.sel", sel, v.sel);
        chk("exec.cin_mux", {cin, muxSel}, {v.cin, v.mux});
        chk("exec.write", write, 0);
        chk("exec.writeRam", writeRam, (v.kind == 2'd1 && i == EC));
        chk("exec.rsp_valid", rsp_valid, 0);
        chk("exec.cmd_ready", cmd_ready, 0);
        step();
      end
      aluOut = ~v.res; Cout = ~v.cout; status = ~v.st;
      if (v.kind == 2'd2) begin
        chk("wb.write", write, 1);
        chk("wb.writeReg", writeReg, v.dst);
        chk("wb.data", data, v.exp_wdata);
        chk("wb.writeRam", writeRam, 0);
        chk("wb.readA", readA, v.srca);
        chk("wb.sel", sel, v.sel);
        chk("wb.rsp_valid", rsp_valid, 0);
        step();
      end
      for (int i = 0; i <= v.rdelay; i++) begin
        rsp_ready = (i == v.rdelay);
        chk("resp.rsp_valid", rsp_valid, 1);
        chk("resp.rsp_result", rsp_result, v.exp_rsp);
        chk("resp.rsp_cout", rsp_cout, v.cout);
        chk("resp.rsp_status", rsp_status, v.st);
        chk("resp.cmd_ready", cmd_ready, 0);
        chk("resp.op_count", op_count, exp_ops);
        chk("resp.write", write, 0);
        chk("resp.writeRam", writeRam, 0);
        step();
      end
      exp_ops++;
      chk("done.rsp_valid", rsp_valid, 0);
      chk("done.op_count", op_count, exp_ops);
      chk("done.cmd_ready", cmd_ready, 1);
      chk("done.readA_hold", readA, v.srca);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(2'd0, 5'd29, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 64'd14, 64'd0, 1'b0, 4'h0, 0);
    tbl[1] = mk(2'd0, 5'd30, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 64'd14, 64'd0, 1'b0, 4'h0, 0);
    tbl[2] = mk(2'd1, 5'd0, 5'd30, 5'd29, 5'b10000, 1'b0, 1'b0, 64'd0, 64'd28, 1'b0, 4'h0, 0);
    tbl[3] = mk(2'd1, 5'd0, 5'd30, 5'd29, 5'b10010, 1'b1, 1'b0, 64'd0, 64'd0, 1'b1, 4'b0100, 1);
    tbl[4] = mk(2'd2, 5'd5, 5'd30, 5'd29, 5'b10000, 1'b0, 1'b1, 64'd0, 64'd28, 1'b0, 4'h0, 0);
    tbl[5] = mk(2'd3, 5'd1, 5'd2, 5'd3, 5'b00001, 1'b1, 1'b1, 64'd9, 64'd9, 1'b0, 4'h0, 0);

    step(); step();
    check_zero("reset");
    reset = 1'b1;
    step();
    chk("post_reset.cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i]);
      if (i == 1) chk("two_loads.op_count", op_count, 2);
    end

    // Response stalled five cycles while a new command is offered.
    keep_valid = 1'b1;
    run_cmd(mk(2'd2, 5'd7, 5'd1, 5'd2, 5'b00011, 1'b1, 1'b1, 64'd0,
               64'hDEAD_BEEF_0123_4567, 1'b1, 4'b1010, 5));
    keep_valid = 1'b0;

    // Reset in the middle of a 3-cycle EXEC hold.
    while (cmd_ready !== 1'b1) step();
    cmd_kind = 2'd1; cmd_srcA = 5'd11; cmd_srcB = 5'd12; cmd_sel = 5'b10000;
    cmd_valid = 1'b1;
    aluOut = 64'h55; Cout = 1'b1; status = 4'hF;
    step();
    cmd_valid = 1'b0;
    chk("rst_exec.readA", readA, 11);
    step();
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_reset.writeRam", writeRam, 0);
      chk("mid_reset.write", write, 0);
      chk("mid_reset.rsp_valid", rsp_valid, 0);
    end
    reset = 1'b1;
    exp_ops = '0;
    run_cmd(mk(2'd0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'h1234, 64'd0, 1'b0, 4'h0, 0));

    // Random commands against the transaction-level model.
    for (int i = 0; i < 60; i++) begin
      rv = mk(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)));
      run_cmd(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
